// File: rtl/pong_if.sv
// Game-sequencer bus: VGA counters and buttons in, renderer state out.
interface pong_if;
   logic       i_pixel_tick;
   logic [9:0] i_h_spot;
   logic [9:0] i_v_spot;
   logic       i_btn_l_up;
   logic       i_btn_l_dn;
   logic       i_btn_r_up;
   logic       i_btn_r_dn;
   logic       i_start;
   logic [9:0] o_ball_x;
   logic [9:0] o_ball_y;
   logic [9:0] o_pad_l_y;
   logic [9:0] o_pad_r_y;
   logic [3:0] o_score_l;
   logic [3:0] o_score_r;
   logic [1:0] o_state;
   logic       o_frame_tick;

   modport master (
      output i_pixel_tick, i_h_spot, i_v_spot,
      output i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn, i_start,
      input  o_ball_x, o_ball_y, o_pad_l_y, o_pad_r_y,
      input  o_score_l, o_score_r, o_state, o_frame_tick
   );

   modport slave (
      input  i_pixel_tick, i_h_spot, i_v_spot,
      input  i_btn_l_up, i_btn_l_dn, i_btn_r_up, i_btn_r_dn, i_start,
      output o_ball_x, o_ball_y, o_pad_l_y, o_pad_r_y,
      output o_score_l, o_score_r, o_state, o_frame_tick
   );
endinterface

// File: rtl/pong_frame_controller.sv
// Pong frame sequencer: one paddle/ball/state update per frame, started at
// the top of vertical blanking so the renderer never sees a partial update.
//
// game state | meaning
// IDLE       | waiting for start, nothing moves
// SERVE      | paddles move, serve counter runs down, ball parked at centre
// PLAY       | paddles and ball move, misses score
// GAMEOVER   | someone reached the winning score, ball frozen
//
// phase      | meaning
// PH_IDLE    | waiting for the frame strobe
// PH_PAD     | paddle update, serve countdown
// PH_BALL    | ball motion, bounce and miss detection
// PH_STATE   | scoring and game-state transitions
module pong_frame_controller #(
   parameter int H_VISIBLE      = 640,
   parameter int V_VISIBLE      = 480,
   parameter int PADDLE_W       = 8,
   parameter int PADDLE_H       = 64,
   parameter int BALL_SIZE      = 8,
   parameter int PADDLE_STEP    = 4,
   parameter int BALL_STEP      = 2,
   parameter int LEFT_PADDLE_X  = 32,
   parameter int RIGHT_PADDLE_X = 600,
   parameter int WIN_SCORE      = 9,
   parameter int SERVE_FRAMES   = 60
) (
   input logic   i_clock,
   input logic   i_reset,
   pong_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0, ST_SERVE = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3;
   localparam logic [1:0] PH_IDLE = 2'd0, PH_PAD = 2'd1, PH_BALL = 2'd2, PH_STATE = 2'd3;

   localparam logic [9:0] BALL_SZ = 10'(BALL_SIZE);
   localparam logic [9:0] STEP_B  = 10'(BALL_STEP);
   localparam logic [9:0] STEP_P  = 10'(PADDLE_STEP);
   localparam logic [9:0] PAD_HT  = 10'(PADDLE_H);
   localparam logic [9:0] PAD_MAX = 10'(V_VISIBLE - PADDLE_H);
   localparam logic [9:0] L_HIT   = 10'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [9:0] R_EDGE  = 10'(RIGHT_PADDLE_X);
   localparam logic [9:0] R_STOP  = 10'(RIGHT_PADDLE_X - BALL_SIZE);
   localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
   localparam logic [9:0] X_MAX   = 10'(H_VISIBLE - BALL_SIZE);
   localparam logic [9:0] Y_MAX   = 10'(V_VISIBLE - BALL_SIZE);
   localparam logic [9:0] X_CTR   = 10'(H_VISIBLE / 2 - BALL_SIZE / 2);
   localparam logic [9:0] Y_CTR   = 10'(V_VISIBLE / 2 - BALL_SIZE / 2);
   localparam logic [9:0] PAD_CTR = 10'(V_VISIBLE / 2 - PADDLE_H / 2);
   localparam logic [3:0] WIN     = 4'(WIN_SCORE);
   localparam int         CNT_W   = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);

   logic [9:0]       ball_x, ball_y, pad_l, pad_r;
   logic [3:0]       score_l, score_r;
   logic [1:0]       state, phase;
   logic             frame_tick, dx_right, dy_down;
   logic             miss_l, miss_r;
   logic [CNT_W-1:0] serve_cnt;

   logic       strobe, ov_l, ov_r;
   logic [9:0] ball_r;
   logic [9:0] nx_x, nx_y;
   logic       nx_dx, nx_dy, nx_miss_l, nx_miss_r;

   assign strobe = bus.i_pixel_tick && (bus.i_h_spot == 10'd0) && (bus.i_v_spot == V_VIS);
   assign ball_r = ball_x + BALL_SZ;
   assign ov_l   = (ball_y + BALL_SZ > pad_l) && (ball_y < pad_l + PAD_HT);
   assign ov_r   = (ball_y + BALL_SZ > pad_r) && (ball_y < pad_r + PAD_HT);

   function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
      if (up && !dn)
         return (y < STEP_P) ? 10'd0 : y - STEP_P;
      else if (dn && !up)
         return (y > PAD_MAX - STEP_P) ? PAD_MAX : y + STEP_P;
      else
         return y;
   endfunction

   // Next ball position/direction from current ball and freshly updated paddles.
   always_comb begin
      nx_x      = ball_x;
      nx_y      = ball_y;
      nx_dx     = dx_right;
      nx_dy     = dy_down;
      nx_miss_l = 1'b0;
      nx_miss_r = 1'b0;
      if (!dx_right) begin
         if (ball_x >= L_HIT && ball_x - STEP_B < L_HIT && ov_l) begin
            nx_x  = L_HIT;
            nx_dx = 1'b1;
         end else if (ball_x < STEP_B) begin
            nx_x      = 10'd0;
            nx_miss_l = 1'b1;
         end else begin
            nx_x = ball_x - STEP_B;
         end
      end else begin
         if (ball_r <= R_EDGE && ball_r + STEP_B > R_EDGE && ov_r) begin
            nx_x  = R_STOP;
            nx_dx = 1'b0;
         end else if (ball_r + STEP_B > H_VIS) begin
            nx_x      = X_MAX;
            nx_miss_r = 1'b1;
         end else begin
            nx_x = ball_x + STEP_B;
         end
      end
      if (!dy_down) begin
         if (ball_y < STEP_B) begin
            nx_y  = 10'd0;
            nx_dy = 1'b1;
         end else begin
            nx_y = ball_y - STEP_B;
         end
      end else begin
         if (ball_y + BALL_SZ + STEP_B > V_VIS) begin
            nx_y  = Y_MAX;
            nx_dy = 1'b0;
         end else begin
            nx_y = ball_y + STEP_B;
         end
      end
   end

   // Three-phase sequencer; game state only changes in PH_STATE.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ball_x     <= X_CTR;
         ball_y     <= Y_CTR;
         pad_l      <= PAD_CTR;
         pad_r      <= PAD_CTR;
         score_l    <= 4'd0;
         score_r    <= 4'd0;
         state      <= ST_IDLE;
         phase      <= PH_IDLE;
         frame_tick <= 1'b0;
         dx_right   <= 1'b1;
         dy_down    <= 1'b1;
         miss_l     <= 1'b0;
         miss_r     <= 1'b0;
         serve_cnt  <= '0;
      end else begin
         frame_tick <= (phase == PH_PAD);
         case (phase)
            PH_IDLE: if (strobe) phase <= PH_PAD;
            PH_PAD: begin
               phase <= PH_BALL;
               if (state == ST_SERVE || state == ST_PLAY) begin
                  pad_l <= pad_next(pad_l, bus.i_btn_l_up, bus.i_btn_l_dn);
                  pad_r <= pad_next(pad_r, bus.i_btn_r_up, bus.i_btn_r_dn);
               end
               if (state == ST_SERVE && serve_cnt != '0) serve_cnt <= serve_cnt - 1'b1;
            end
            PH_BALL: begin
               phase  <= PH_STATE;
               miss_l <= 1'b0;
               miss_r <= 1'b0;
               if (state == ST_PLAY) begin
                  ball_x   <= nx_x;
                  ball_y   <= nx_y;
                  dx_right <= nx_dx;
                  dy_down  <= nx_dy;
                  miss_l   <= nx_miss_l;
                  miss_r   <= nx_miss_r;
               end
            end
            default: begin
               phase <= PH_IDLE;
               case (state)
                  ST_IDLE, ST_OVER: if (bus.i_start) begin
                     state     <= ST_SERVE;
                     score_l   <= 4'd0;
                     score_r   <= 4'd0;
                     ball_x    <= X_CTR;
                     ball_y    <= Y_CTR;
                     dx_right  <= 1'b1;
                     serve_cnt <= SERVE_LOAD;
                  end
                  ST_SERVE: if (serve_cnt == '0) state <= ST_PLAY;
                  default: if (miss_l || miss_r) begin
                     if (miss_l) score_r <= score_r + 4'd1;
                     else        score_l <= score_l + 4'd1;
                     if ((miss_l ? score_r : score_l) + 4'd1 == WIN) begin
                        state <= ST_OVER;
                     end else begin
                        state     <= ST_SERVE;
                        ball_x    <= X_CTR;
                        ball_y    <= Y_CTR;
                        serve_cnt <= SERVE_LOAD;
                        dx_right  <= miss_r;
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign bus.o_ball_x     = ball_x;
   assign bus.o_ball_y     = ball_y;
   assign bus.o_pad_l_y    = pad_l;
   assign bus.o_pad_r_y    = pad_r;
   assign bus.o_score_l    = score_l;
   assign bus.o_score_r    = score_r;
   assign bus.o_state      = state;
   assign bus.o_frame_tick = frame_tick;
endmodule

// File: tb/tb_pong_frame_controller.sv
// Randomized bench for pong_frame_controller against a per-frame game model.
module tb_pong_frame_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pong_if bus ();
   pong_frame_controller dut (.i_clock(clk), .i_reset(rst), .bus(bus));

   int n_chk = 0, n_pass = 0;

   // game model, in plain pixel arithmetic
   int mbx, mby, mpl, mpr, msl, msr, mst, mdx, mdy, mcnt;
   bit m_left_missed, m_right_missed;
   bit ul, dl, ur, dr, st;
   bit trk_l, trk_r;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic m_reset();
      mbx = 316; mby = 236; mpl = 208; mpr = 208;
      msl = 0; msr = 0; mst = 0; mdx = 1; mdy = 1; mcnt = 0;
   endtask

   function automatic int pad_move(input int p, input bit up, input bit dn);
      if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
      if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
      return p;
   endfunction

   function automatic bit overlaps(input int p);
      return (mby + 8 > p) && (mby < p + 64);
   endfunction

   task automatic m_paddles();
      if (mst == 1 || mst == 2) begin
         mpl = pad_move(mpl, ul, dl);
         mpr = pad_move(mpr, ur, dr);
      end
      if (mst == 1 && mcnt > 0) mcnt--;
   endtask

   task automatic m_ball();
      int nx, ny;
      m_left_missed = 0; m_right_missed = 0;
      if (mst != 2) return;
      if (mdx == 0) begin
         if (mbx >= 40 && mbx - 2 < 40 && overlaps(mpl)) begin nx = 40; mdx = 1; end
         else if (mbx - 2 < 0) begin nx = 0; m_left_missed = 1; end
         else nx = mbx - 2;
      end else begin
         if (mbx + 8 <= 600 && mbx + 10 > 600 && overlaps(mpr)) begin nx = 592; mdx = 0; end
         else if (mbx + 10 > 640) begin nx = 632; m_right_missed = 1; end
         else nx = mbx + 2;
      end
      if (mdy == 0) begin
         if (mby - 2 < 0) begin ny = 0; mdy = 1; end
         else ny = mby - 2;
      end else begin
         if (mby + 10 > 480) begin ny = 472; mdy = 0; end
         else ny = mby + 2;
      end
      mbx = nx; mby = ny;
   endtask

   task automatic m_state();
      case (mst)
         0, 3: if (st) begin
            mst = 1; msl = 0; msr = 0; mbx = 316; mby = 236; mdx = 1; mcnt = 60;
         end
         1: if (mcnt == 0) mst = 2;
         default: if (m_left_missed || m_right_missed) begin
            if (m_left_missed) msr++; else msl++;
            if (msr == 9 || msl == 9) mst = 3;
            else begin
               mst = 1; mbx = 316; mby = 236; mcnt = 60;
               mdx = m_left_missed ? 0 : 1;
            end
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_ball_x"}, bus.o_ball_x, mbx);
      chk({tag, "_ball_y"}, bus.o_ball_y, mby);
      chk({tag, "_pad_l"}, bus.o_pad_l_y, mpl);
      chk({tag, "_pad_r"}, bus.o_pad_r_y, mpr);
      chk({tag, "_score_l"}, bus.o_score_l, msl);
      chk({tag, "_score_r"}, bus.o_score_r, msr);
      chk({tag, "_state"}, bus.o_state, mst);
      chk({tag, "_tick"}, bus.o_frame_tick, 0);
   endtask

   // Non-strobe counter values, including near-misses of the strobe decode.
   task automatic drive_junk();
      case ($urandom_range(0, 3))
         0: begin bus.i_pixel_tick = 1'b0; bus.i_h_spot = 10'd0; bus.i_v_spot = 10'd480; end
         1: begin bus.i_pixel_tick = 1'b1; bus.i_h_spot = 10'd1; bus.i_v_spot = 10'd480; end
         2: begin bus.i_pixel_tick = 1'b1; bus.i_h_spot = 10'd0; bus.i_v_spot = 10'd479; end
         default: begin
            bus.i_pixel_tick = 1'($urandom_range(0, 1));
            bus.i_h_spot = 10'($urandom_range(1, 799));
            bus.i_v_spot = 10'($urandom_range(0, 524));
         end
      endcase
   endtask

   task automatic drive_strobe();
      bus.i_pixel_tick = 1'b1; bus.i_h_spot = 10'd0; bus.i_v_spot = 10'd480;
   endtask

   // While busy a real strobe must be ignored, so present one now and then.
   task automatic drive_busy();
      if ($urandom_range(0, 3) == 0) drive_strobe();
      else drive_junk();
   endtask

   task automatic pick_inputs(input bit allow_start);
      if (trk_l) begin ul = (mpl + 32 > mby + 8); dl = (mpl + 32 < mby); end
      else begin ul = 1'($urandom_range(0, 1)); dl = 1'($urandom_range(0, 1)); end
      if (trk_r) begin ur = (mpr + 32 > mby + 8); dr = (mpr + 32 < mby); end
      else begin ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); end
      st = allow_start && ($urandom_range(0, 15) == 0);
      bus.i_btn_l_up = ul; bus.i_btn_l_dn = dl;
      bus.i_btn_r_up = ur; bus.i_btn_r_dn = dr;
      bus.i_start = st;
   endtask

   task automatic run_frame(input bit allow_start, input bit do_reset);
      @(negedge clk);
      pick_inputs(allow_start);
      drive_strobe();
      @(posedge clk); #1 drive_busy();
      @(negedge clk);
      chk("tick_t0", bus.o_frame_tick, 0);
      m_paddles();
      @(posedge clk); #1 drive_busy();
      @(negedge clk);
      chk("tick_t1", bus.o_frame_tick, 1);
      chk("p1_pad_l", bus.o_pad_l_y, mpl);
      chk("p1_pad_r", bus.o_pad_r_y, mpr);
      m_ball();
      @(posedge clk); #1 drive_busy();
      @(negedge clk);
      chk("tick_t2", bus.o_frame_tick, 0);
      chk("p2_ball_x", bus.o_ball_x, mbx);
      chk("p2_ball_y", bus.o_ball_y, mby);
      if (do_reset) begin
         rst = 1'b1;
         #1 m_reset();
         check_all("midrst");
         @(posedge clk); #1 rst = 1'b0;
         drive_junk();
         return;
      end
      m_state();
      @(posedge clk); #1 drive_junk();
      @(negedge clk);
      check_all("p3");
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1 drive_junk();
         @(negedge clk);
         chk("tick_gap", bus.o_frame_tick, 0);
      end
   endtask

   initial begin
      bus.i_btn_l_up = 0; bus.i_btn_l_dn = 0; bus.i_btn_r_up = 0; bus.i_btn_r_dn = 0;
      bus.i_start = 0;
      trk_l = 0; trk_r = 0;
      drive_junk();
      m_reset();
      #12;
      check_all("reset");
      @(posedge clk); #1 rst = 1'b0;
      run_frame(1'b0, 1'b0);
      run_frame(1'b0, 1'b0);
      for (int f = 0; f < 6000; f++) begin
         if (f % 150 == 0) begin
            trk_l = ($urandom_range(0, 2) != 0);
            trk_r = ($urandom_range(0, 2) != 0);
         end
         run_frame(1'b1, (f == 2500 || f == 5200));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
